mux_share_arbiter: RTL and testbench
====================================

Name: mux_share_arbiter

Overview:
- Round-robin arbiter and burst sequencer that shares one 2:1 operand-mux path (bank of 1-bit 2:1 muxes, DATA_W wide) between two operand streams feeding the shared multiply-accumulate datapath.
- Grants one requester for a fixed burst of BURST_LEN beats (one matrix row/column), drives the mux select, and gates valid/ready so only the granted stream advances.

Parameters:
- DATA_W, 8, operand width in bits.
- BURST_LEN, 4, beats per grant (matrix dimension); legal range 1..255.
- CNT_W, 8, beat-counter width; must hold BURST_LEN-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 wants a burst; level, held until burst_done for its grant.
- req1  input  1  requester 1 wants a burst; same rules.
- in0_valid  input  1  requester 0 beat valid.
- in0_data  input  DATA_W  requester 0 operand.
- in0_ready  output  1  requester 0 beat accepted.
- in1_valid  input  1  requester 1 beat valid.
- in1_data  input  DATA_W  requester 1 operand.
- in1_ready  output  1  requester 1 beat accepted.
- out_valid  output  1  beat valid toward the datapath.
- out_data  output  DATA_W  muxed operand.
- out_ready  input  1  datapath accepts beat.
- sel  output  1  mux select, registered; 1 = input 0 (mux port a), 0 = input 1 (mux port b).
- grant  output  2  one-hot current owner; 00 = idle.
- busy  output  1  grant != 00.
- burst_done  output  1  one-cycle pulse on the final accepted beat of a burst.

Behaviour:
- Reset: state IDLE, grant=00, sel=0, busy=0, beat count=0, priority pointer=requester 0. burst_done=0, out_valid=0, in0_ready=0, in1_ready=0. rst overrides everything, including mid-burst; any partial burst is abandoned with no burst_done.
- States: IDLE, OWN0, OWN1. grant=01 in OWN0, 10 in OWN1. sel=1 in OWN0, 0 in OWN1/IDLE. sel and grant change only on clock edges.
- IDLE: one requester asserted -> go to its OWN state next cycle. Both asserted -> the requester named by the priority pointer wins. Neither -> stay.
- Datapath path is combinational, zero latency:
  - out_data = sel ? in0_data : in1_data.
  - out_valid = owner's in_valid while in OWN, else 0.
  - owner's in_ready = out_ready; the non-owner's ready = 0. No ready in IDLE.
- Beat = out_valid && out_ready; the beat count increments per beat.
- Final beat is count == BURST_LEN-1 with a beat. On it:
  - burst_done=1 and count clears.
  - Priority pointer moves to the other requester.
  - Re-arbitration uses the updated pointer and the current req0/req1. Next state is OWNx for the winner, or IDLE if none; no bubble cycle on a back-to-back handover.
- Same requester may win again only if the other is not requesting.
- Requester deasserting req mid-burst does not end the grant; the burst completes only by beat count.
- Stall (out_ready=0 or owner in_valid=0) holds state and count indefinitely.
- BURST_LEN=1: every beat is a final beat; pure per-beat round-robin.
- The non-owner's in_valid is ignored and must never reach out_valid.

Decomposition:
- Shared package (matmul_pkg): state encoding constants (ST_IDLE=2'd0, ST_OWN0=2'd1, ST_OWN1=2'd2), SEL_IN0=1'b1 and SEL_IN1=1'b0, default DATA_W and BURST_LEN.
- Sub-module: instantiate the existing 1-bit 2:1 mux DATA_W times (generate loop) for out_data.
- The arbiter FSM plus counter is kept in this module; no further split.

Test Plan:
- Reset: hold rst 2 cycles with req0=req1=1 -> grant=00, sel=0, all readies 0. First post-reset cycle grant=01, since the pointer starts at requester 0.
- Single burst: req0=1, in0_valid=1, out_ready=1, data 0x11..0x14, BURST_LEN=4 -> out_data 0x11..0x14 on 4 consecutive beats, sel=1, burst_done only on 0x14, then IDLE.
- Contention: req0=req1=1 continuously -> grants alternate 01,10,01,10 every 4 beats with no idle cycle. in1_ready stays 0 during OWN0 even with in1_valid=1.
- Stall: out_ready low for 5 cycles after beat 2 -> count holds at 2, no beat and no burst_done. Resuming gives exactly 2 more beats before handover.
- Drop mid-burst and reset abort: req0 falls after beat 1 -> grant stays 01 until beat 4. Separately, rst pulse after beat 2 -> grant=00 next cycle and no burst_done.
- BURST_LEN=1 build: req0=req1=1 -> grant toggles every accepted beat and burst_done is high each beat.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the operand-sharing arbiter: state encoding,
// mux select polarity, default sizes and the arbitration helper.
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    // Select polarity of the shared mux bank: port a carries stream 0.
    localparam logic SEL_IN0 = 1'b1;
    localparam logic SEL_IN1 = 1'b0;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_BURST_LEN = 4;

    // Pick the next owner from the request levels.
    // A pointer of 0 favours requester 0 when both ask.
    function automatic state_t arbitrate(input logic r0, input logic r1, input logic ptr);
        state_t winner;
        if (r0 && r1) begin
            winner = ptr ? ST_OWN1 : ST_OWN0;
        end else if (r0) begin
            winner = ST_OWN0;
        end else if (r1) begin
            winner = ST_OWN1;
        end else begin
            winner = ST_IDLE;
        end
        return winner;
    endfunction

endpackage

// File: rtl/mux_share_arbiter_mux2.sv
// Single-bit 2:1 multiplexer; replicated to form the shared operand path.
module mux2 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);

    // s high passes port a, s low passes port b.
    always_comb begin
        y = s ? a : b;
    end

endmodule

// File: rtl/mux_share_arbiter.sv
// Round-robin burst arbiter that shares one operand mux path between two
// streams. The owner keeps the path for BURST_LEN accepted beats, then the
// grant moves on, back-to-back when the other side is waiting.
module mux_share_arbiter
    import matmul_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    output logic              in1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              sel,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              burst_done
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             ptr;
    logic             next_ptr;
    logic             beat;

    // State, beat counter, priority pointer and the registered mux
    // select / grant, all derived from the next state so they change
    // only on the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            ptr   <= 1'b0;
            sel   <= SEL_IN1;
            grant <= 2'b00;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            ptr   <= next_ptr;
            sel   <= (next_state == ST_OWN0) ? SEL_IN0 : SEL_IN1;
            grant <= {next_state == ST_OWN1, next_state == ST_OWN0};
        end
    end

    // Handshake gating for the owner, beat counting and re-arbitration
    // on the final beat so a waiting requester takes over without a bubble.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_ptr   = ptr;
        out_valid  = 1'b0;
        in0_ready  = 1'b0;
        in1_ready  = 1'b0;
        burst_done = 1'b0;
        beat       = 1'b0;

        case (state)
            ST_IDLE: begin
                next_state = arbitrate(req0, req1, ptr);
            end
            ST_OWN0: begin
                out_valid = in0_valid;
                in0_ready = out_ready;
            end
            ST_OWN1: begin
                out_valid = in1_valid;
                in1_ready = out_ready;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        beat = out_valid && out_ready;

        if (beat) begin
            if (cnt == LAST_BEAT) begin
                burst_done = 1'b1;
                next_cnt   = '0;
                next_ptr   = (state == ST_OWN0);
                next_state = arbitrate(req0, req1, next_ptr);
            end else begin
                next_cnt = cnt + CNT_W'(1);
            end
        end
    end

    // Busy simply mirrors a non-empty grant.
    always_comb begin
        busy = |grant;
    end

    // One 2:1 mux per operand bit, all steered by the registered select.
    for (genvar i = 0; i < DATA_W; i++) begin : g_mux
        mux2 u_mux (
            .a (in0_data[i]),
            .b (in1_data[i]),
            .s (sel),
            .y (out_data[i])
        );
    end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Directed bench for the shared-mux burst arbiter: a BURST_LEN=4 instance
// and a BURST_LEN=1 instance driven from the same stimulus.
module tb_mux_share_arbiter;

    logic       clk;
    logic       rst;
    logic       req0;
    logic       req1;
    logic       in0_valid;
    logic [7:0] in0_data;
    logic       in1_valid;
    logic [7:0] in1_data;
    logic       out_ready;

    logic       in0_ready4, in1_ready4, out_valid4, sel4, busy4, done4;
    logic [7:0] out_data4;
    logic [1:0] grant4;

    logic       in0_ready1, in1_ready1, out_valid1, sel1, busy1, done1;
    logic [7:0] out_data1;
    logic [1:0] grant1;

    int total;
    int bad;

    mux_share_arbiter #(.DATA_W(8), .BURST_LEN(4), .CNT_W(8)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .req1       (req1),
        .in0_valid  (in0_valid),
        .in0_data   (in0_data),
        .in0_ready  (in0_ready4),
        .in1_valid  (in1_valid),
        .in1_data   (in1_data),
        .in1_ready  (in1_ready4),
        .out_valid  (out_valid4),
        .out_data   (out_data4),
        .out_ready  (out_ready),
        .sel        (sel4),
        .grant      (grant4),
        .busy       (busy4),
        .burst_done (done4)
    );

    mux_share_arbiter #(.DATA_W(8), .BURST_LEN(1), .CNT_W(8)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .req1       (req1),
        .in0_valid  (in0_valid),
        .in0_data   (in0_data),
        .in0_ready  (in0_ready1),
        .in1_valid  (in1_valid),
        .in1_data   (in1_data),
        .in1_ready  (in1_ready1),
        .out_valid  (out_valid1),
        .out_data   (out_data1),
        .out_ready  (out_ready),
        .sel        (sel1),
        .grant      (grant1),
        .busy       (busy1),
        .burst_done (done1)
    );

    // 10-unit clock period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r0, input logic r1, input logic v0, input logic v1,
                                 input logic [7:0] d0, input logic [7:0] d1, input logic ordy);
        req0      = r0;
        req1      = r1;
        in0_valid = v0;
        in1_valid = v1;
        in0_data  = d0;
        in1_data  = d1;
        out_ready = ordy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic resetDut();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1);

        // Reset held two cycles with both requesters asking
        tick();
        tick();
        checkOutput("rst_grant", grant4, 2'b00);
        checkOutput("rst_sel", sel4, 1'b0);
        checkOutput("rst_busy", busy4, 1'b0);
        checkOutput("rst_in0_ready", in0_ready4, 1'b0);
        checkOutput("rst_in1_ready", in1_ready4, 1'b0);
        checkOutput("rst_out_valid", out_valid4, 1'b0);
        checkOutput("rst_done", done4, 1'b0);
        rst = 1'b0;
        tick();
        checkOutput("post_rst_grant", grant4, 2'b01);

        // Contention: OWN0 burst then immediate OWN1 burst then back
        $display("[TB] contention");
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'(8'h20 + b), 8'(8'hA0 + b), 1'b1);
            checkOutput("c0_data", out_data4, 8'(8'h20 + b));
            checkOutput("c0_in1_ready", in1_ready4, 1'b0);
            checkOutput("c0_sel", sel4, 1'b1);
            checkOutput("c0_grant", grant4, 2'b01);
            checkOutput("c0_done", done4, (b == 3));
            tick();
        end
        checkOutput("c_hand_grant", grant4, 2'b10);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'(8'h20 + b), 8'(8'hA0 + b), 1'b1);
            checkOutput("c1_data", out_data4, 8'(8'hA0 + b));
            checkOutput("c1_in0_ready", in0_ready4, 1'b0);
            checkOutput("c1_sel", sel4, 1'b0);
            checkOutput("c1_grant", grant4, 2'b10);
            checkOutput("c1_done", done4, (b == 3));
            tick();
        end
        checkOutput("c_back_grant", grant4, 2'b01);

        // Single burst 0x11..0x14, req0 dropped with the final beat
        $display("[TB] single burst");
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        tick();
        checkOutput("s_grant", grant4, 2'b01);
        checkOutput("s_sel", sel4, 1'b1);
        for (int b = 0; b < 4; b++) begin
            applyStimulus((b != 3), 1'b0, 1'b1, 1'b1, 8'(8'h11 + b), 8'h55, 1'b1);
            checkOutput("s_data", out_data4, 8'(8'h11 + b));
            checkOutput("s_valid", out_valid4, 1'b1);
            checkOutput("s_done", done4, (b == 3));
            tick();
        end
        checkOutput("s_idle_grant", grant4, 2'b00);
        checkOutput("s_idle_busy", busy4, 1'b0);

        // Stall after two beats, then exactly two more beats
        $display("[TB] stall");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        tick();
        for (int b = 0; b < 2; b++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h30 + b), 8'h00, 1'b1);
            checkOutput("st_pre_done", done4, 1'b0);
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h3F, 8'h00, 1'b0);
            checkOutput("st_hold_ready", in0_ready4, 1'b0);
            checkOutput("st_hold_done", done4, 1'b0);
            checkOutput("st_hold_grant", grant4, 2'b01);
            tick();
        end
        for (int b = 0; b < 2; b++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'(8'h32 + b), 8'h00, 1'b1);
            checkOutput("st_post_done", done4, (b == 1));
            checkOutput("st_post_grant", grant4, 2'b01);
            tick();
        end
        checkOutput("st_hand_grant", grant4, 2'b10);

        // Requester 0 drops after beat 1; burst still runs to four beats
        $display("[TB] drop mid-burst");
        resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        tick();
        for (int b = 0; b < 4; b++) begin
            applyStimulus((b == 0), 1'b0, 1'b1, 1'b0, 8'(8'h40 + b), 8'h00, 1'b1);
            checkOutput("d_grant", grant4, 2'b01);
            checkOutput("d_done", done4, (b == 3));
            tick();
        end
        checkOutput("d_idle_grant", grant4, 2'b00);

        // Reset pulse after two beats abandons the burst silently
        $display("[TB] reset abort");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        tick();
        for (int b = 0; b < 2; b++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h50 + b), 8'h00, 1'b1);
            tick();
        end
        rst = 1'b1;
        #1;
        checkOutput("ra_done_in_rst", done4, 1'b0);
        tick();
        checkOutput("ra_grant", grant4, 2'b00);
        checkOutput("ra_busy", busy4, 1'b0);
        checkOutput("ra_done", done4, 1'b0);
        rst = 1'b0;

        // BURST_LEN=1 instance: grant alternates every beat
        $display("[TB] single-beat bursts");
        resetDut();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h61, 8'h92, 1'b1);
        tick();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'(8'h61 + k), 8'(8'h92 + k), 1'b1);
            checkOutput("b1_grant", grant1, (k % 2 == 0) ? 2'b01 : 2'b10);
            checkOutput("b1_done", done1, 1'b1);
            checkOutput("b1_data", out_data1, (k % 2 == 0) ? 8'(8'h61 + k) : 8'(8'h92 + k));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
